// File: rtl/mips32_prog_loader.sv
// Boot-path program loader for the pipelined MIPS32 core: receives a header plus image words
// over valid/ready, writes them through one memory port, then clears the PC and releases the core.
module mips32_prog_loader #(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] HALT_WORD = 32'hfc000000
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_pc_clr,
   output logic              cpu_run,
   output logic              busy,
   output logic              err_len,
   output logic              no_halt,
   output logic [15:0]       words_loaded
);

   typedef enum logic [2:0] {IDLE, HDR, LOAD, RELEASE, RUN, ERR} state_e;

   state_e              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                err_len_q, err_len_d;
   logic                no_halt_q, no_halt_d;
   logic                halt_seen_q, halt_seen_d;
   logic [15:0]         words_loaded_q, words_loaded_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         idx_q, idx_d;

   logic fire;
   logic can_start;
   logic hdr_len_zero;
   logic last_idx;

   assign fire         = in_valid && in_ready_q;
   assign can_start    = start && (state_q == IDLE || state_q == RUN || state_q == ERR);
   assign hdr_len_zero = (in_data[15:0] == 16'd0);
   assign last_idx     = (idx_q == len_q - 16'd1);

   // NOTE: async reset clears every flop, so all outputs drop the instant rst_n falls; memory
   // contents live outside this block and are intentionally left as written.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         in_ready_q     <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         err_len_q      <= 1'b0;
         no_halt_q      <= 1'b0;
         halt_seen_q    <= 1'b0;
         words_loaded_q <= '0;
         base_q         <= '0;
         len_q          <= '0;
         idx_q          <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
         state_q        <= state_d;
         in_ready_q     <= in_ready_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         err_len_q      <= err_len_d;
         no_halt_q      <= no_halt_d;
         halt_seen_q    <= halt_seen_d;
         words_loaded_q <= words_loaded_d;
         base_q         <= base_d;
         len_q          <= len_d;
         idx_q          <= idx_d;
      end
   end

   always_comb begin
      // NOTE: defaulting state_d first keeps this block latch-free on every path.
      state_d = state_q;
      unique case (state_q)
         IDLE, RUN, ERR: if (start) state_d = HDR;
         HDR: begin
            if (fire) begin
               if (hdr_len_zero && in_last)       state_d = RELEASE;
               else if (hdr_len_zero || in_last) state_d = ERR;
               else                              state_d = LOAD;
            end
         end
         LOAD: begin
            if (fire) begin
               if (last_idx && in_last)       state_d = RELEASE;
               else if (last_idx || in_last) state_d = ERR;
            end
         end
         RELEASE: state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_we_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      err_len_d      = err_len_q;
      no_halt_d      = no_halt_q;
      halt_seen_d    = halt_seen_q;
      words_loaded_d = words_loaded_q;
      base_d         = base_q;
      len_d          = len_q;
      idx_d          = idx_q;

      if (can_start) begin
         err_len_d      = 1'b0;
         words_loaded_d = '0;
         halt_seen_d    = 1'b0;
      end

      if (state_q == HDR && fire) begin
         base_d = in_data[16+ADDR_W-1:16];
         len_d  = in_data[15:0];
         idx_d  = '0;
      end

      if (state_q == LOAD && fire) begin
         mem_we_d       = 1'b1;
         mem_addr_d     = base_q + idx_q[ADDR_W-1:0];
         mem_wdata_d    = in_data;
         idx_d          = idx_q + 16'd1;
         words_loaded_d = words_loaded_q + 16'd1;
         if (in_data == HALT_WORD) halt_seen_d = 1'b1;
      end

      if (state_d == ERR && state_q != ERR) err_len_d = 1'b1;
      if (state_q == RELEASE)               no_halt_d = !halt_seen_q;

      // Ready trails entry into HDR by one edge and drops on the edge that ends the transfer.
      in_ready_d = (state_q == HDR || state_q == LOAD) && (state_d == HDR || state_d == LOAD);
   end

   always_comb begin
      in_ready     = in_ready_q;
      mem_we       = mem_we_q;
      mem_addr     = mem_addr_q;
      mem_wdata    = mem_wdata_q;
      cpu_pc_clr   = (state_q == RELEASE);
      cpu_run      = (state_q == RUN);
      busy         = (state_q == HDR) || (state_q == LOAD) || (state_q == RELEASE);
      err_len      = err_len_q;
      no_halt      = no_halt_q;
      words_loaded = words_loaded_q;
   end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: an image-level model predicts every memory write and the
// end-of-session flags; a monitor compares each write as it appears.
module tb_mips32_prog_loader;

   localparam int          ADDR_W = 10;
   localparam int          DEPTH  = 1 << ADDR_W;
   localparam logic [31:0] HALT   = 32'hfc000000;

   logic              clk1 = 1'b0;
   logic              rst_n, start, in_valid, in_last;
   logic [31:0]       in_data;
   logic              in_ready, mem_we, cpu_pc_clr, cpu_run, busy, err_len, no_halt;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [15:0]       words_loaded;

   mips32_prog_loader #(.ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
      .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_pc_clr(cpu_pc_clr), .cpu_run(cpu_run), .busy(busy),
      .err_len(err_len), .no_halt(no_halt), .words_loaded(words_loaded)
   );

   always #5 clk1 = ~clk1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_addr [0:255];
   logic [31:0] exp_data [0:255];
   int          exp_wr = 0;
   int          exp_rd = 0;
   logic [31:0] log_addr [0:255];
   int          log_n  = 0;
   int          pc_cnt = 0;
   logic [31:0] img [0:31];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Each observed write must be the next one the image model predicted.
   always @(negedge clk1) begin
      if (rst_n) begin
         if (cpu_pc_clr) pc_cnt++;
         if (mem_we) begin
            check("write_pending", {31'd0, exp_wr > exp_rd}, 32'd1);
            if (exp_wr > exp_rd) begin
               check("wr_addr", {22'd0, mem_addr}, exp_addr[exp_rd]);
               check("wr_data", mem_wdata, exp_data[exp_rd]);
               exp_rd++;
            end
            if (log_n < 256) begin
               log_addr[log_n] = {22'd0, mem_addr};
               log_n++;
            end
         end
      end
   end

   task automatic send(input logic [31:0] data, input bit last, input bit bubbly);
      bit hs = 1'b0;
      if (bubbly) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            @(posedge clk1); #1;
         end
      end
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      for (int k = 0; k < 20 && !hs; k++) begin
         @(negedge clk1);
         hs = in_ready;
         @(posedge clk1); #1;
      end
      check("handshake", {31'd0, hs}, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk1); #1;
      start = 1'b0;
      check("start_run_low", {31'd0, cpu_run}, 32'd0);
      check("start_ready_low", {31'd0, in_ready}, 32'd0);
      check("start_err_clr", {31'd0, err_len}, 32'd0);
      check("start_wl_clr", {16'd0, words_loaded}, 32'd0);
      @(posedge clk1); #1;
      check("ready_rise", {31'd0, in_ready}, 32'd1);
   endtask

   // Sends header(base,len) then n words of img; n==len is a good image, n<len ends early.
   task automatic run_image(input int base, input int len, input int n, input bit bubbly);
      bit          ok   = (n == len);
      bit          halt = 1'b0;
      int          pc0  = pc_cnt;
      logic [9:0]  b    = base[9:0];
      logic [15:0] l    = len[15:0];
      for (int i = 0; i < n; i++) begin
         exp_addr[exp_wr] = (base + i) % DEPTH;
         exp_data[exp_wr] = img[i];
         exp_wr++;
         if (img[i] == HALT) halt = 1'b1;
      end
      send({6'd0, b, l}, n == 0, bubbly);
      for (int i = 0; i < n; i++) send(img[i], i == n - 1, bubbly);
      @(negedge clk1);
      check("pc_clr_pulse", {31'd0, cpu_pc_clr}, {31'd0, ok});
      check("run_stalled", {31'd0, cpu_run}, 32'd0);
      check("ready_fell", {31'd0, in_ready}, 32'd0);
      check("busy_release", {31'd0, busy}, {31'd0, ok});
      @(posedge clk1); #1;
      check("cpu_run", {31'd0, cpu_run}, {31'd0, ok});
      check("busy_done", {31'd0, busy}, 32'd0);
      check("err_len", {31'd0, err_len}, {31'd0, !ok});
      check("words_loaded", {16'd0, words_loaded}, n);
      if (ok) check("no_halt", {31'd0, no_halt}, {31'd0, !halt});
      check("pc_clr_count", pc_cnt - pc0, {31'd0, ok});
      check("writes_drained", exp_rd, exp_wr);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out"}, {26'd0, in_ready, mem_we, cpu_pc_clr, cpu_run, busy, err_len}, 32'd0);
      check({tag, "_nohalt"}, {31'd0, no_halt}, 32'd0);
      check({tag, "_addr"}, {22'd0, mem_addr}, 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_wl"}, {16'd0, words_loaded}, 32'd0);
   endtask

   initial begin
      int s;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      #12;
      check_all_zero("reset");
      @(negedge clk1); rst_n = 1'b1;
      @(posedge clk1); #1;

      // 11-word program at base 0.
      img[0] = 32'h280a00c8; img[1] = 32'h28020001; img[2]  = 32'h0e94a000;
      img[3] = 32'h21430000; img[4] = 32'h0e94a000; img[5]  = 32'h14431000;
      img[6] = 32'h2c630001; img[7] = 32'h0e94a000; img[8]  = 32'h3460fffc;
      img[9] = 32'h2542fffe; img[10] = HALT;
      s = log_n;
      do_start();
      run_image(0, 11, 11, 1'b0);
      check("prog_first_addr", log_addr[s], 32'd0);
      check("prog_last_addr", log_addr[s+10], 32'd10);

      // Reload from RUN with a wrapping base.
      @(negedge clk1);
      check("in_run", {31'd0, cpu_run}, 32'd1);
      @(posedge clk1); #1;
      for (int i = 0; i < 4; i++) img[i] = i + 1;
      s = log_n;
      do_start();
      run_image(1022, 4, 4, 1'b0);
      check("wrap_a0", log_addr[s],   32'd1022);
      check("wrap_a1", log_addr[s+1], 32'd1023);
      check("wrap_a2", log_addr[s+2], 32'd0);
      check("wrap_a3", log_addr[s+3], 32'd1);
      check("wrap_nohalt", {31'd0, no_halt}, 32'd1);

      // Early in_last: len=3, last on word 2.
      img[0] = 32'hdead0001; img[1] = 32'hdead0002;
      do_start();
      run_image(0, 3, 2, 1'b0);
      repeat (3) @(posedge clk1);
      #1;
      check("err_stalled", {31'd0, cpu_run}, 32'd0);
      check("err_sticky", {31'd0, err_len}, 32'd1);

      // Recovery with a single HALT word.
      img[0] = HALT;
      do_start();
      run_image(5, 1, 1, 1'b0);

      // Missing HALT.
      img[0] = 32'h1; img[1] = 32'h2;
      do_start();
      run_image(0, 2, 2, 1'b0);
      check("missing_halt", {31'd0, no_halt}, 32'd1);

      // Empty image goes straight to release.
      do_start();
      run_image(7, 0, 0, 1'b0);

      // Bubbly stream of 8 words.
      for (int i = 0; i < 8; i++) img[i] = $urandom;
      img[3] = HALT;
      do_start();
      run_image(16, 8, 8, 1'b1);

      // Asynchronous reset mid-load, between clock edges.
      img[0] = 32'hcafe0000; img[1] = 32'hcafe0001;
      for (int i = 0; i < 2; i++) begin
         exp_addr[exp_wr] = 32 + i;
         exp_data[exp_wr] = img[i];
         exp_wr++;
      end
      do_start();
      send({6'd0, 10'd32, 16'd4}, 1'b0, 1'b0);
      send(img[0], 1'b0, 1'b0);
      send(img[1], 1'b0, 1'b0);
      @(negedge clk1);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      check("rst_drained", exp_rd, exp_wr);
      @(negedge clk1); rst_n = 1'b1;
      @(posedge clk1); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
